spi_slave_rx_mc: RTL and testbench
==================================

Name: spi_slave_rx_mc

Overview:
- Parametrised SPI-slave receive block for the ADC input path. It deserialises frames of CH_BITS channel-tag bits followed by DATA_WIDTH data bits, MSB first.
- Reports the most recent word with its channel tag, and keeps one holding register per channel.
- Adds SCK polarity selection, a configurable idle timeout, a frame-error pulse and per-channel storage.
- Sits between the external ADC/MCU SPI pins and the oscillator control logic; runs on the system clock and oversamples SCK.

Parameters:
- DATA_WIDTH, 16, data bits per frame (2..32).
- CH_BITS, 2, channel-tag bits sent before the data; NUM_CH = 2**CH_BITS (CH_BITS 1..4).
- IDLE_TIMEOUT, 511, system clocks without an SCK edge before a partial frame is aborted.
- CPOL, 0, SCK idle level. 0: idle low, sample on rising edge. 1: idle high, sample on falling edge.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- spi_clock_in  in  1  raw SCK, asynchronous to clock.
- spi_data_in  in  1  raw MOSI, asynchronous to clock.
- data_out  out  DATA_WIDTH  last complete data word.
- channel_out  out  CH_BITS  tag of the last complete word.
- data_valid  out  1  one-cycle pulse when data_out/channel_out update.
- ch_data  out  NUM_CH*DATA_WIDTH  per-channel holding registers; channel n occupies bits [n*DATA_WIDTH +: DATA_WIDTH].
- busy  out  1  high while a frame is in progress (any state other than IDLE).
- frame_error  out  1  one-cycle pulse on timeout abort.

Behaviour:
- Reset is asynchronous and active-high; clock is `clock`. On reset, all outputs, ch_data, the shift register, counters and state clear to 0, and the state returns to IDLE.
- Synchronisers: SCK and MOSI each pass through 2 flip-flops. SCK is XORed with CPOL so the internal "active edge" is always a rising edge of sck_n. Edge detection uses the synchronised sck_n against its registered previous value.
- Frame length: FRAME_LEN = CH_BITS + DATA_WIDTH. Bit counter width is clog2(FRAME_LEN+1). Shift-in is MSB first; the first bit received is the channel-tag MSB.
- State IDLE:
  - On an active edge, sample MOSI as bit 0, set bit count to 1 and go to RECV.
  - A falling edge in IDLE is ignored.
- State RECV:
  - Each active edge shifts in the synchronised MOSI and increments the bit count.
  - When the edge that shifts in bit FRAME_LEN-1 occurs, go to DONE.
  - Any SCK edge (either direction) clears the idle counter. Otherwise the counter increments, saturating at IDLE_TIMEOUT+1.
  - When the counter exceeds IDLE_TIMEOUT: pulse frame_error for 1 cycle, discard the partial frame and go to IDLE. Outputs and ch_data are unchanged.
- State DONE: waits for sck_n to return to its idle level (internal low).
  - On the cycle that low is seen: load data_out and channel_out, load ch_data[channel], pulse data_valid for exactly 1 cycle and go to IDLE.
  - The idle timeout also runs in DONE; on expiry, pulse frame_error, drop the frame and go to IDLE.
- Latency: data_valid rises 3 system clocks after the raw SCK return-to-idle edge (2 synchroniser stages plus 1 register).
- data_out, channel_out and ch_data hold their values until the next valid frame. Only the addressed channel's ch_data entry changes.
- An active edge in the same cycle as timeout expiry: the timeout wins and the edge is not sampled. The next active edge starts a new frame from IDLE.
- Reset asserted mid-frame aborts the frame immediately with no data_valid and no frame_error.
- data_valid and frame_error are never high in the same cycle.
- SCK period must be at least 4 system clocks; behaviour at faster SCK is not guaranteed.

Optional Feature:
- Macro: SPI_RX_CS_EN.
- When defined:
  - Adds port `spi_cs_n in 1`, active-low chip select, with its own 2-flip-flop synchroniser.
  - Active edges are ignored while synchronised cs_n is high.
  - cs_n rising while in RECV or DONE forces IDLE and pulses frame_error, except in DONE where it completes the frame exactly as a return-to-idle would.
  - cs_n falling clears the bit counter and the idle counter.
- When undefined: no port; framing relies solely on bit count and idle timeout as described above.

Decomposition:
- Package spi_rx_pkg holds the state enum (IDLE, RECV, DONE), a clog2 function, and constants for the default widths and timeout.
- One sub-module, sync_2ff (parametrised width), is instantiated for SCK/MOSI (and CS when SPI_RX_CS_EN is defined).
- The state machine, shifter and channel bank remain in the top module.

Test Plan:
- Reset, then send one frame with CH_BITS=2, DATA_WIDTH=16: tag 2'b10, data 0xA5C3, SCK period 8 clocks -> one data_valid pulse; data_out=0xA5C3, channel_out=2; ch_data[2]=0xA5C3; other channels remain 0.
- Send 4 frames with tags 0..3 and data 0x0001, 0x0202, 0x3030, 0xFFFF -> 4 data_valid pulses; each ch_data entry holds its word; data_out=0xFFFF after the last frame.
- Send 9 bits, then hold SCK high for 600 clocks -> frame_error pulses once after 512 idle clocks; no data_valid; a following full frame tagged 1 with 0x1234 is received correctly.
- CPOL=1 build, SCK idling high, frame tag 3 with data 0x8001 -> data_out=0x8001 and channel_out=3; no spurious start from the initial high level.
- Assert reset after 10 bits of a frame -> all outputs 0 and busy=0; no data_valid or frame_error pulse; the next frame is received correctly.
- With SPI_RX_CS_EN: raise cs_n after 8 bits -> frame_error pulse and ch_data unchanged; SCK toggling with cs_n high -> busy stays 0.

Source files
------------

// File: rtl/spi_rx_pkg.sv
// Shared types and defaults for the oversampling SPI-slave receiver.
package spi_rx_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RECV = 2'd1, DONE = 2'd2} rx_state_e;

  localparam int DEF_DATA_WIDTH   = 16;
  localparam int DEF_CH_BITS      = 2;
  localparam int DEF_IDLE_TIMEOUT = 511;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs; reset level is configurable.
module sync_2ff #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);
  logic [W-1:0] s1_q, s2_q;

  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      s1_q <= RST_VAL;
      s2_q <= RST_VAL;
    end else begin
      s1_q <= d_i;
      s2_q <= s1_q;
    end

  assign q_o = s2_q;
endmodule

// File: rtl/spi_slave_rx_mc.sv
// SPI-slave receiver: tag+data frames, per-channel holding registers, idle timeout.
// Optional chip select is enabled with `define SPI_RX_CS_EN.
module spi_slave_rx_mc import spi_rx_pkg::*; #(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int CH_BITS      = DEF_CH_BITS,
  parameter int IDLE_TIMEOUT = DEF_IDLE_TIMEOUT,
  parameter int CPOL         = 0
) (
  input  logic                               clock,
  input  logic                               reset,
`ifdef SPI_RX_CS_EN
  input  logic                               spi_cs_n,
`endif
  input  logic                               spi_clock_in,
  input  logic                               spi_data_in,
  output logic [DATA_WIDTH-1:0]              data_out,
  output logic [CH_BITS-1:0]                 channel_out,
  output logic                               data_valid,
  output logic [(2**CH_BITS)*DATA_WIDTH-1:0] ch_data,
  output logic                               busy,
  output logic                               frame_error
);
  localparam int NUM_CH    = 2**CH_BITS;
  localparam int FRAME_LEN = CH_BITS + DATA_WIDTH;
  localparam int CW        = clog2(FRAME_LEN + 1);
  localparam int IW        = clog2(IDLE_TIMEOUT + 2);

  logic sck_n, mosi_s, sck_prev_q;
  logic cs_rise, cs_fall, cs_hi;
  logic act_rise, any_edge, timeout;
  rx_state_e                    state_q;
  logic [FRAME_LEN-1:0]         shift_q;
  logic [CW-1:0]                cnt_q;
  logic [IW-1:0]                idle_q, idle_d;
  logic [DATA_WIDTH-1:0]        data_q;
  logic [CH_BITS-1:0]           chan_q;
  logic [NUM_CH*DATA_WIDTH-1:0] ch_data_q;
  logic                         dv_q, fe_q;

  // Polarity is folded in before synchronising so reset (0) always means idle.
  sync_2ff #(.W(2)) u_sync (
    .clock (clock),
    .reset (reset),
    .d_i   ({spi_clock_in ^ (CPOL != 0), spi_data_in}),
    .q_o   ({sck_n, mosi_s})
  );

`ifdef SPI_RX_CS_EN
  logic cs_s, cs_prev_q;
  sync_2ff #(.W(1), .RST_VAL(1'b1)) u_sync_cs (
    .clock (clock),
    .reset (reset),
    .d_i   (spi_cs_n),
    .q_o   (cs_s)
  );
  always_ff @(posedge clock or posedge reset)
    if (reset) cs_prev_q <= 1'b1;
    else       cs_prev_q <= cs_s;
  assign cs_rise = cs_s & ~cs_prev_q;
  assign cs_fall = ~cs_s & cs_prev_q;
  assign cs_hi   = cs_s;
`else
  assign cs_rise = 1'b0;
  assign cs_fall = 1'b0;
  assign cs_hi   = 1'b0;
`endif

  assign act_rise = sck_n & ~sck_prev_q & ~cs_hi;
  assign any_edge = sck_n ^ sck_prev_q;
  assign timeout  = (state_q != IDLE) && (idle_q > IW'(IDLE_TIMEOUT));

  always_comb begin
    idle_d = idle_q;
    if (state_q == IDLE || any_edge || timeout || cs_fall) idle_d = '0;
    else if (idle_q <= IW'(IDLE_TIMEOUT))                 idle_d = idle_q + IW'(1);
  end

  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state_q    <= IDLE;
      sck_prev_q <= 1'b0;
      shift_q    <= '0;
      cnt_q      <= '0;
      idle_q     <= '0;
      data_q     <= '0;
      chan_q     <= '0;
      ch_data_q  <= '0;
      dv_q       <= 1'b0;
      fe_q       <= 1'b0;
    end else begin
      sck_prev_q <= sck_n;
      idle_q     <= idle_d;
      dv_q       <= 1'b0;
      fe_q       <= 1'b0;
      case (state_q)
        IDLE:
          if (act_rise) begin
            shift_q <= {shift_q[FRAME_LEN-2:0], mosi_s};
            cnt_q   <= CW'(1);
            state_q <= RECV;
          end
        RECV:
          if (timeout || cs_rise) begin
            fe_q    <= 1'b1;
            shift_q <= '0;
            cnt_q   <= '0;
            state_q <= IDLE;
          end else if (act_rise) begin
            shift_q <= {shift_q[FRAME_LEN-2:0], mosi_s};
            cnt_q   <= cnt_q + CW'(1);
            if (cnt_q == CW'(FRAME_LEN - 1)) state_q <= DONE;
          end
        DONE:
          if (timeout) begin
            fe_q    <= 1'b1;
            shift_q <= '0;
            cnt_q   <= '0;
            state_q <= IDLE;
          end else if (!sck_n || cs_rise) begin
            data_q  <= shift_q[DATA_WIDTH-1:0];
            chan_q  <= shift_q[FRAME_LEN-1 -: CH_BITS];
            ch_data_q[shift_q[FRAME_LEN-1 -: CH_BITS]*DATA_WIDTH +: DATA_WIDTH]
                    <= shift_q[DATA_WIDTH-1:0];
            dv_q    <= 1'b1;
            cnt_q   <= '0;
            state_q <= IDLE;
          end
        default: state_q <= IDLE;
      endcase
      if (cs_fall) cnt_q <= '0;
    end

  assign data_out    = data_q;
  assign channel_out = chan_q;
  assign data_valid  = dv_q;
  assign ch_data     = ch_data_q;
  assign busy        = (state_q != IDLE);
  assign frame_error = fe_q;
endmodule

// File: tb/tb_spi_slave_rx_mc.sv
// Directed bench: frame-level model (queue of sent words, per-channel array) checked every cycle.
module tb_spi_slave_rx_mc;
  logic clock = 1'b0, reset = 1'b1;
  logic sck0 = 1'b0, mosi0 = 1'b0;
  logic sck1 = 1'b1, mosi1 = 1'b0;
  logic [15:0] data_out0, data_out1;
  logic [1:0]  chan0, chan1;
  logic        dv0, dv1, busy0, busy1, fe0, fe1;
  logic [63:0] chd0, chd1;

  int checks = 0, errors = 0, fe_seen = 0, dv1_cnt = 0;

  typedef struct packed { logic [1:0] ch; logic [15:0] d; } frm_t;
  frm_t        expq[$];
  logic [15:0] m_ch [4];
  logic [15:0] m_data;
  logic [1:0]  m_chan;

  always #5 clock = ~clock;

  spi_slave_rx_mc #(.CPOL(0)) dut0 (
    .clock(clock), .reset(reset),
`ifdef SPI_RX_CS_EN
    .spi_cs_n(1'b0),
`endif
    .spi_clock_in(sck0), .spi_data_in(mosi0), .data_out(data_out0),
    .channel_out(chan0), .data_valid(dv0), .ch_data(chd0), .busy(busy0),
    .frame_error(fe0));

  spi_slave_rx_mc #(.CPOL(1)) dut1 (
    .clock(clock), .reset(reset),
`ifdef SPI_RX_CS_EN
    .spi_cs_n(1'b0),
`endif
    .spi_clock_in(sck1), .spi_data_in(mosi1), .data_out(data_out1),
    .channel_out(chan1), .data_valid(dv1), .ch_data(chd1), .busy(busy1),
    .frame_error(fe1));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h @%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] model_pack();
    logic [63:0] v;
    for (int i = 0; i < 4; i++) v[i*16 +: 16] = m_ch[i];
    return v;
  endfunction

  // Every cycle: outputs must match the last completed frame, and the bank must match the model.
  always @(negedge clock) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) m_ch[i] = '0;
      m_data = '0;
      m_chan = '0;
    end else begin
      if (dv0) begin
        if (expq.size() == 0) chk("unexpected_dv", 1, 0);
        else begin
          frm_t e;
          e = expq.pop_front();
          m_ch[e.ch] = e.d;
          m_data     = e.d;
          m_chan     = e.ch;
        end
      end
      if (fe0) fe_seen++;
      chk("dv_fe_excl", dv0 & fe0, 0);
      chk("data_out", data_out0, m_data);
      chk("channel_out", chan0, m_chan);
      chk("ch_data", chd0, model_pack());
      if (dv1) dv1_cnt++;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(posedge clock); #2; end
  endtask

  // Drive one lane: 'act' is the internal active level, converted to raw SCK per polarity.
  task automatic drv(input int inst, input logic act, input logic b);
    if (inst == 0) begin sck0 = act;  mosi0 = b; end
    else           begin sck1 = ~act; mosi1 = b; end
  endtask

  task automatic send(input int inst, input logic [1:0] ch, input logic [15:0] d,
                      input int nbits, input bit close);
    logic [17:0] f;
    f = {ch, d};
    for (int i = 0; i < nbits; i++) begin
      drv(inst, 1'b0, f[17-i]);
      tick(4);
      drv(inst, 1'b1, f[17-i]);
      tick(4);
    end
    if (close) begin
      drv(inst, 1'b0, 1'b0);
      if (inst == 0 && nbits == 18) expq.push_back('{ch, d});
    end
  endtask

  initial begin
    int n;
    tick(3);
    reset = 1'b0;
    tick(4);
    chk("rst_data", data_out0, 0);
    chk("rst_chan", chan0, 0);
    chk("rst_dv", dv0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_fe", fe0, 0);
    chk("rst_chd", chd0, 0);
    chk("cpol1_idle_busy", busy1, 0);

    // Single frame with latency check on the return-to-idle edge
    send(0, 2'b10, 16'hA5C3, 18, 0);
    chk("busy_done", busy0, 1);
    sck0 = 1'b0;
    expq.push_back('{2'b10, 16'hA5C3});
    tick(2);
    chk("lat_dv_early", dv0, 0);
    tick(1);
    chk("lat_dv", dv0, 1);
    tick(1);
    chk("dv_one_cycle", dv0, 0);
    chk("f1_data", data_out0, 16'hA5C3);
    chk("f1_chan", chan0, 2);
    chk("f1_chd", chd0, 64'h0000_A5C3_0000_0000);

    // One frame per channel
    send(0, 2'd0, 16'h0001, 18, 1); tick(6);
    send(0, 2'd1, 16'h0202, 18, 1); tick(6);
    send(0, 2'd2, 16'h3030, 18, 1); tick(6);
    send(0, 2'd3, 16'hFFFF, 18, 1); tick(6);
    chk("f4_chd", chd0, 64'hFFFF_3030_0202_0001);
    chk("f4_data", data_out0, 16'hFFFF);
    chk("f4_chan", chan0, 3);

    // Partial frame, SCK parked high: timeout abort
    send(0, 2'd1, 16'hDEAD, 9, 0);
    chk("busy_partial", busy0, 1);
    n = 4;
    while (!fe0 && n < 700) begin tick(1); n++; end
    chk("timeout_lat", n, 516);
    tick(1);
    chk("fe_one_cycle", fe0, 0);
    chk("idle_after_to", busy0, 0);
    tick(600 - n);
    send(0, 2'd1, 16'h1234, 18, 1); tick(6);
    chk("after_to_chd", chd0, 64'hFFFF_3030_1234_0001);
    chk("after_to_data", data_out0, 16'h1234);

    // Reset mid-frame
    send(0, 2'd2, 16'h5555, 10, 0);
    reset = 1'b1;
    sck0 = 1'b0;
    tick(2);
    chk("mrst_data", data_out0, 0);
    chk("mrst_chan", chan0, 0);
    chk("mrst_chd", chd0, 0);
    chk("mrst_busy", busy0, 0);
    chk("mrst_dv", dv0, 0);
    chk("mrst_fe", fe0, 0);
    reset = 1'b0;
    tick(4);
    chk("mrst_idle", busy0, 0);
    send(0, 2'd0, 16'hBEEF, 18, 1); tick(6);
    chk("mrst_next_chd", chd0, 64'h0000_0000_0000_BEEF);

    // Inverted-polarity instance, SCK idling high from time zero
    chk("cpol1_pre_dv", dv1_cnt, 0);
    send(1, 2'd3, 16'h8001, 18, 1); tick(6);
    chk("cpol1_dv_cnt", dv1_cnt, 1);
    chk("cpol1_data", data_out1, 16'h8001);
    chk("cpol1_chan", chan1, 3);
    chk("cpol1_chd", chd1, 64'h8001_0000_0000_0000);
    chk("cpol1_fe", fe1, 0);

    tick(4);
    chk("pending_frames", expq.size(), 0);
    chk("fe_count", fe_seen, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
